// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch controller with PC, single-outstanding imem port and IF/ID register
// Holds, bubbles or discards fetched instructions under hazard-unit stall/flush and branch redirect.

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_stall,
  input  logic        if_id_stall,
  input  logic        if_id_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic        redir;
  logic        drop;
  logic        new_avail;
  logic [31:0] new_pc;
  logic [31:0] new_instr;

  // Targets are word aligned; the low two bits of redirect_pc carry no information.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    new_avail     = 1'b0;
    new_pc        = req_pc_q;
    new_instr     = imem_rdata;
    imem_req      = 1'b0;

    redir = redirect_valid && (state_q != S_IDLE);
    drop  = if_id_flush || redirect_valid;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = !pc_stall && !redirect_valid;
        if (imem_req && imem_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!(kill_q || drop)) begin
            if (!if_id_stall) begin
              new_avail = 1'b1;
              new_pc    = req_pc_q;
              new_instr = imem_rdata;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_rdata;
              state_d      = S_HOLD;
            end
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A flush or redirect empties the skid, so there is nothing left to hold.
        if (drop) begin
          state_d = S_REQ;
        end else if (!if_id_stall && skid_valid_q) begin
          new_avail    = 1'b1;
          new_pc       = skid_pc_q;
          new_instr    = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redir) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end

    if (drop) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      skid_valid_d  = 1'b0;
    end else if (if_id_stall) begin
      if_id_valid_d = if_id_valid_q;
    end else if (new_avail) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = new_pc;
      if_id_instr_d = new_instr;
    end else begin
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      kill_q        <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      kill_q        <= kill_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven cycle vectors plus a reset-in-HOLD sequence for fetch_ctrl

module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_stall = 1'b0;
  logic        if_id_stall = 1'b0;
  logic        if_id_flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int n_applied = 0;
  int n_miscompare = 0;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ps, st, fl, rv;
    logic [31:0] rpc;
    logic        rdy, rval;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] d(input logic [31:0] a);
    return 32'hD000_0000 | a;
  endfunction

  task automatic add(input logic ps, st, fl, rv, input logic [31:0] rpc,
                     input logic rdy, rval, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_v, input logic [31:0] e_pc, e_instr);
    vec_t v;
    v.ps = ps; v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.rdy = rdy; v.rval = rval; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_instr = e_instr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_v, input logic [31:0] e_pc, e_instr);
    chk({tag, " imem_req"},    {31'h0, imem_req},    {31'h0, e_req});
    chk({tag, " imem_addr"},   imem_addr,            e_addr);
    chk({tag, " if_id_valid"}, {31'h0, if_id_valid}, {31'h0, e_v});
    chk({tag, " if_id_pc"},    if_id_pc,             e_pc);
    chk({tag, " if_id_instr"}, if_id_instr,          e_instr);
  endtask

  initial begin
    //   ps st fl rv rpc       rdy rv  rdata        req addr      v  if_pc     if_instr
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h0,   0, 32'h0,   NOP);        // C0 idle
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h0,   0, 32'h0,   NOP);        // C1 req 0
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h0),    0, 32'h4,   0, 32'h0,   NOP);
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h4,   1, 32'h0,   d(32'h0));
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h4),    0, 32'h8,   0, 32'h0,   d(32'h0));
    add(1, 0, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h8,   1, 32'h4,   d(32'h4));   // C5 pc_stall x3
    add(1, 0, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h8,   0, 32'h4,   d(32'h4));
    add(1, 0, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h8,   0, 32'h4,   d(32'h4));
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h8,   0, 32'h4,   d(32'h4));
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h8),    0, 32'hC,   0, 32'h4,   d(32'h4));
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'hC,   1, 32'h8,   d(32'h8));
    add(0, 1, 0, 0, 32'h0,   1, 1, d(32'hC),    0, 32'h10,  0, 32'h8,   d(32'h8));   // C11 if_id_stall x4
    add(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h10,  0, 32'h8,   d(32'h8));
    add(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h10,  0, 32'h8,   d(32'h8));
    add(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h10,  0, 32'h8,   d(32'h8));
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h10,  0, 32'h8,   d(32'h8));
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0,       1, 32'h10,  1, 32'hC,   d(32'hC));   // C16 not ready
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h10,  0, 32'hC,   d(32'hC));
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h10),   0, 32'h14,  0, 32'hC,   d(32'hC));
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h14,  1, 32'h10,  d(32'h10));
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h18,  0, 32'h10,  d(32'h10));  // C20 k=2
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h14),   0, 32'h18,  0, 32'h10,  d(32'h10));
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h18,  1, 32'h14,  d(32'h14));
    add(0, 0, 1, 0, 32'h0,   1, 1, d(32'h18),   0, 32'h1C,  0, 32'h14,  d(32'h14));  // C23 flush + rvalid
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h1C,  0, 32'h14,  NOP);
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h1C),   0, 32'h20,  0, 32'h14,  NOP);
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h20,  1, 32'h1C,  d(32'h1C));
    add(0, 0, 0, 1, 32'h103, 1, 0, 32'h0,       0, 32'h24,  0, 32'h1C,  d(32'h1C));  // C27 redirect, 0x20 pending
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h100, 0, 32'h1C,  NOP);
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h20),   0, 32'h100, 0, 32'h1C,  NOP);        // killed response
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h100, 0, 32'h1C,  NOP);
    add(0, 0, 0, 0, 32'h0,   1, 1, d(32'h100),  0, 32'h104, 0, 32'h1C,  NOP);
    add(1, 0, 0, 1, 32'h40,  1, 0, 32'h0,       0, 32'h104, 1, 32'h100, d(32'h100)); // C32 redirect beats pc_stall
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h40,  0, 32'h100, NOP);
    add(0, 1, 0, 0, 32'h0,   1, 1, d(32'h40),   0, 32'h44,  0, 32'h100, NOP);
    add(0, 1, 0, 1, 32'h80,  1, 0, 32'h0,       0, 32'h44,  0, 32'h100, NOP);        // C35 redirect in HOLD
    add(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h80,  0, 32'h100, NOP);
    add(0, 1, 0, 0, 32'h0,   1, 1, d(32'h80),   0, 32'h84,  0, 32'h100, NOP);
    add(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h84,  0, 32'h100, NOP);        // C38 in HOLD

    repeat (2) @(negedge clk);
    #1 chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      pc_stall       = tbl[i].ps;
      if_id_stall    = tbl[i].st;
      if_id_flush    = tbl[i].fl;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      imem_ready     = tbl[i].rdy;
      imem_rvalid    = tbl[i].rval;
      imem_rdata     = tbl[i].rdata;
      #1 chk_all($sformatf("C%0d", i), tbl[i].e_req, tbl[i].e_addr,
                 tbl[i].e_v, tbl[i].e_pc, tbl[i].e_instr);
      @(negedge clk);
    end

    // Still in S_HOLD holding the 0x80 instruction: async reset mid-cycle.
    #1 chk_all("hold_pre", 1'b0, 32'h84, 1'b0, 32'h100, NOP);
    rst_n = 1'b0;
    #1 chk_all("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    @(negedge clk);
    rst_n       = 1'b1;
    if_id_stall = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1 chk_all("rel_c0", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    @(negedge clk);
    #1 chk_all("rel_c1", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
    @(negedge clk);
    #1 chk_all("rel_c2", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    #1 chk_all("rel_c3", 1'b0, 32'h4, 1'b0, 32'h0, NOP);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1 chk_all("rel_c4", 1'b1, 32'h4, 1'b1, 32'h0, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller and IF/ID pipeline register for the 5-stage RV32I core. It owns the PC, issues one instruction-memory request at a time, and captures returned instructions into the IF/ID register. It is the consumer of the hazard unit's `pc_stall`, `if_id_stall` and `if_id_flush` outputs and of the branch unit's redirect. It holds, bubbles or discards fetched instructions accordingly.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction word placed in IF/ID on reset or flush.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_stall` in 1: hazard unit; blocks issue of a new fetch request.
- `if_id_stall` in 1: hazard unit; IF/ID register holds its contents.
- `if_id_flush` in 1: hazard unit or branch unit; IF/ID is invalidated.
- `redirect_valid` in 1: branch or jump taken in EX.
- `redirect_pc` in 32: target address. Bits [1:0] are ignored and treated as 0.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; always equals the PC.
- `imem_ready` in 1: memory accepts the request this cycle when high with `imem_req`.
- `imem_rvalid` in 1: response valid. It arrives at least 1 cycle after acceptance, in order, with at most one outstanding.
- `imem_rdata` in 32: instruction word.
- `if_id_valid` out 1: IF/ID holds a live instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_instr` out 32: instruction in IF/ID.

## Operation
**Registers:**
- `pc`
- `req_pc`: address of the outstanding request.
- `state`
- `kill`: discard the outstanding response.
- skid buffer: `skid_valid`, `skid_pc`, `skid_instr`.
- IF/ID: `if_id_valid`, `if_id_pc`, `if_id_instr`.

**Reset values:**
- `pc` = RESET_PC, `state` = S_IDLE, `kill` = 0, `skid_valid` = 0.
- `if_id_valid` = 0, `if_id_pc` = 0, `if_id_instr` = NOP_INSTR.
- `imem_req` = 0, `imem_addr` = RESET_PC.

**State machine:**
- S_IDLE: `imem_req` = 0. Always goes to S_REQ on the next cycle, so the first request appears in the 2nd cycle after reset release.
- S_REQ: `imem_req` = !pc_stall && !redirect_valid.
  - On acceptance (`imem_req` && `imem_ready`): `req_pc` <= pc, pc <= pc+4 (wraps modulo 2^32), go to S_WAIT.
  - Otherwise remain in S_REQ.
- S_WAIT: `imem_req` = 0. On `imem_rvalid`:
  - If `kill`, or `if_id_flush` this cycle: discard the response, clear `kill`, go to S_REQ.
  - Else if `if_id_stall` = 0: load IF/ID with {1, req_pc, imem_rdata}, go to S_REQ.
  - Else: load the skid buffer, go to S_HOLD.
- S_HOLD: `imem_req` = 0. When `if_id_stall` = 0: move the skid into IF/ID, clear `skid_valid`, go to S_REQ.

**Redirect** (`redirect_valid` = 1, evaluated in every state except S_IDLE):
- pc <= {redirect_pc[31:2], 2'b00}.
- No request is issued that cycle.
- In S_WAIT without `imem_rvalid`: set `kill`.
- In S_WAIT with `imem_rvalid`: the response is discarded and the state goes to S_REQ.
- In S_HOLD: the skid is dropped and the state goes to S_REQ.
- `pc_stall` does not block a redirect.

**IF/ID update priority per cycle:**
1. `rst_n` low.
2. `if_id_flush` or `redirect_valid`: valid <= 0, instr <= NOP_INSTR, pc unchanged, skid cleared.
3. `if_id_stall`: hold.
4. New instruction available (S_WAIT response or S_HOLD release): load it.
5. Otherwise: valid <= 0 (bubble), pc and instr unchanged.

**Flush without redirect:** `if_id_flush` alone does not change `pc`, `kill` or the outstanding request. A response arriving in the same cycle is discarded.

**Reset mid-operation:** an asynchronous reset returns all state to the reset values above. A response to a pre-reset request that arrives after reset is ignored, because `state` = S_IDLE/S_REQ.

## Timing
- Fetch latency: request accepted at edge N; rvalid in cycle N+k (k≥1); IF/ID valid from edge N+k+1.
- Peak throughput: one instruction per 2 cycles (k=1). The next request is issued in the cycle after the response.
- `imem_req` and `imem_addr` are combinational from registered state plus `pc_stall`/`redirect_valid`. There is no combinational path from `imem_ready` or `imem_rvalid` to `imem_req`.
- Redirect at edge R: the first request to the target is issued in cycle R+1 if no fetch is outstanding. Otherwise it is issued in the cycle after the killed response arrives.
- `if_id_stall` held for S cycles with a response pending: that instruction enters IF/ID on the edge ending the first cycle with `if_id_stall` = 0. No instruction is lost or duplicated.

## Test plan
- Reset release, memory with `imem_ready`=1 and k=1, pc_stall=0 -> IF/ID shows valid pc 0x0, 0x4, 0x8 with the matching rdata, each valid every other cycle, bubbles in between.
- `pc_stall`=1 for 3 cycles while in S_REQ -> `imem_req`=0 for those 3 cycles, and pc holds (e.g. 0x8) throughout.
- `if_id_stall`=1 for 4 cycles while a response to 0xC arrives -> the skid holds it and IF/ID holds its old value. One cycle after the stall drops, IF/ID = {1, 0xC, data}, and the next request is to 0x10.
- `redirect_valid`=1 with `redirect_pc`=0x103 while the 0x20 fetch is outstanding (k=3) -> the 0x20 response is discarded and never reaches IF/ID. The next `imem_addr` is 0x100, and IF/ID is invalid with NOP_INSTR until the 0x100 fetch returns.
- `if_id_flush`=1 coinciding with `imem_rvalid` -> the response is dropped, `if_id_valid`=0 and instr=0x00000013, pc is unchanged, and fetch continues from pc.
- `rst_n` pulsed low while in S_HOLD -> pc=RESET_PC, skid and IF/ID cleared, `imem_req`=0 for 1 cycle after release.
